uart_byte_tx: RTL and testbench
===============================

UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, SHALL be the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the line bit rate.
REQ-003 Parameter PARITY, default 0, SHALL select the parity bit: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, SHALL be the stop-bit count; legal values are 1 or 2.
REQ-005 clk  input  1  SHALL be the single system clock; all logic is rising-edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 tx_data  input  8  SHALL be the byte to send, sampled only on an accepted tx_start.
REQ-008 tx_start  input  1  SHALL be a one-cycle request to send tx_data.
REQ-009 tx_busy  output  1  SHALL be high while a frame is in progress.
REQ-010 tx_done  output  1  SHALL be a one-cycle pulse at frame completion.
REQ-011 txd  output  1  SHALL be the serial line; idle is high.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD, using integer truncation; the default is 434.
REQ-013 The baud counter SHALL be wide enough for CLKS_PER_BIT-1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, the outputs SHALL be txd=1, tx_busy=0, and the baud counter SHALL be held at 0.
REQ-016 When tx_start=1 in IDLE at a clock edge, that edge SHALL:
- latch tx_data into the shift register;
- compute the parity bit from the latched byte;
- enter START, with txd=0 and tx_busy=1 registered on the same edge.
REQ-017 tx_start SHALL be ignored while tx_busy=1; the latched byte SHALL NOT change, and the request is not queued.
REQ-018 Each bit SHALL be driven for exactly CLKS_PER_BIT cycles, timed by the counter counting 0..CLKS_PER_BIT-1.
REQ-019 Bit order on txd SHALL be:
- the start bit (0);
- data bits 0..7, LSB first;
- the parity bit, only if PARITY!=0;
- STOP_BITS stop bits (1).
REQ-020 Even parity SHALL drive the XOR of the data bits; odd parity SHALL drive its complement.
REQ-021 Frame length F SHALL be (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles; tx_busy SHALL be high for exactly F cycles.
REQ-022 On the edge that ends the last stop bit, the block SHALL enter IDLE, set tx_busy=0, and assert tx_done=1 for exactly one cycle.
REQ-023 A tx_start in the first IDLE cycle, while tx_done=1, SHALL be accepted; back-to-back frames therefore have zero idle gap.
REQ-024 txd SHALL be driven directly from a register, with no combinational path from any input.
REQ-025 The bit index SHALL count 0..7 in DATA and 0..STOP_BITS-1 in STOP, and SHALL clear on every state change.
REQ-026 An illegal PARITY value SHALL be treated as 0, and an illegal STOP_BITS value as 1.

Reset
REQ-027 While rst=1, the block SHALL hold: state=IDLE, txd=1, tx_busy=0, tx_done=0, counters=0, shift and parity registers=0.
REQ-028 rst asserted mid-frame SHALL force txd=1 immediately, without waiting for a clock edge; the partial frame is abandoned.
REQ-029 The first tx_start after rst deasserts SHALL be accepted on the next edge.

Verification
REQ-030 Defaults (8N1, 434 clocks per bit), tx_data=8'h41, tx_start pulse:
- txd sequence 0,1,0,0,0,0,0,1,0,1, each bit 434 cycles;
- tx_busy high for exactly 4340 cycles;
- one tx_done pulse.
REQ-031 PARITY=1 with 8'h41 SHALL drive a parity bit of 0; PARITY=2 SHALL drive 1. STOP_BITS=2 SHALL make the frame 12*434=5208 cycles.
REQ-032 With tx_data=8'h55, pulse tx_start again 100 cycles into the frame with tx_data=8'hAA: the frame SHALL carry 8'h55 only, with no second frame.
REQ-033 Issue tx_start in the tx_done cycle, with 8'h00 then 8'hFF: the two frames SHALL be contiguous, and tx_busy SHALL show a single-cycle low gap.
REQ-034 Assert rst during data bit 3: txd=1 and tx_busy=0 immediately. After release, a new 8'h5A frame SHALL be transmitted correctly.
REQ-035 Drive the block with the command controller's handshake (tx_start only when tx_busy=0) for 16 random bytes: a UART monitor SHALL decode all 16 in order.

Source files
------------

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte UART transmitter.
// Frame: start bit, 8 data bits (LSB first), optional parity bit, 1 or 2 stop bits.
// txd comes straight from a flop. An asynchronous reset therefore forces the line idle at once.
module uart_byte_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       txd
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   // Out-of-range settings fall back to no parity and a single stop bit.
   localparam int   PAR_EFF   = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
   localparam int   STOP_EFF  = (STOP_BITS == 2) ? 2 : 1;
   localparam logic PAR_EN    = (PAR_EFF != 0);
   localparam logic PAR_ODD   = (PAR_EFF == 2);
   localparam logic [2:0] STOP_LAST = 3'(STOP_EFF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_MAX);

   // Next-state logic. txd_d is the line level for the next bit slot. It is registered on the
   // same edge that changes state, so txd has no path from any input.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
               shift_d = tx_data;
               par_d   = (^tx_data) ^ PAR_ODD;
               state_d = S_START;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
               txd_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PAR_EN) begin
                     state_d = S_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  // Shift right so the next data bit is always in shift_q[0].
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_STOP;
               txd_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers. The reset is asynchronous, so txd goes idle without a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd     = txd_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench for uart_byte_tx.
// Five instances cover the default 8N1, even parity, odd parity with 2 stop bits,
// a fast clock with truncated bit timing, and illegal parameter values.
// The stimulus pushes expected bytes into a queue. The line monitor decodes frames and pops them.
module tb_uart_byte_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] start_v = '0;
   logic [7:0] data_v [5];
   wire  [4:0] txd_v, busy_v, done_v;

   // Bench-side view of each instance: clocks per bit, effective parity mode, stop bits.
   int cpb_v [5] = '{434, 434, 434, 10, 8};
   int par_v [5] = '{0, 1, 2, 1, 0};
   int ns_v  [5] = '{1, 1, 2, 2, 1};

   int total = 0;
   int bad   = 0;
   int sel   = 0;
   int n_rx  = 0;
   int rst_cnt = 0;
   logic [7:0] sb_q [$];

   uart_byte_tx u0 (.clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_start(start_v[0]),
                    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));
   uart_byte_tx #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_start(start_v[1]),
                    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));
   uart_byte_tx #(.PARITY(2), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .tx_data(data_v[2]),
                    .tx_start(start_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .txd(txd_v[2]));
   uart_byte_tx #(.CLK_FREQ(1000000), .BAUD(99000), .PARITY(1), .STOP_BITS(2)) u3 (.clk(clk),
                    .rst(rst), .tx_data(data_v[3]), .tx_start(start_v[3]),
                    .tx_busy(busy_v[3]), .tx_done(done_v[3]), .txd(txd_v[3]));
   uart_byte_tx #(.CLK_FREQ(1000), .BAUD(125), .PARITY(3), .STOP_BITS(3)) u4 (.clk(clk),
                    .rst(rst), .tx_data(data_v[4]), .tx_start(start_v[4]),
                    .tx_busy(busy_v[4]), .tx_done(done_v[4]), .txd(txd_v[4]));

   always @(posedge rst) rst_cnt <= rst_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected line bits in transmit order (bit 0 first). Unused upper positions are 1.
   function automatic logic [11:0] frame_bits(input logic [7:0] d, input int par);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (par != 0) f[9] = (^d) ^ (par == 2);
      return f;
   endfunction

   // Line monitor. It samples the first and last cycle of every bit slot, so it checks
   // both the bit value and the exact bit length. A reset during a frame abandons the decode.
   initial begin
      int cp, nb, rc0;
      logic ab;
      logic [11:0] of, ol;
      logic [7:0] d;
      forever begin
         @(posedge clk); #1;
         if (!rst && txd_v[sel] === 1'b0) begin
            cp  = cpb_v[sel];
            nb  = 9 + ((par_v[sel] != 0) ? 1 : 0) + ns_v[sel];
            rc0 = rst_cnt;
            ab  = 1'b0;
            of  = '1;
            ol  = '1;
            for (int k = 0; k < nb && !ab; k++) begin
               if (k > 0) begin @(posedge clk); #1; end
               of[k] = txd_v[sel];
               repeat (cp - 1) begin @(posedge clk); #1; end
               ol[k] = txd_v[sel];
               if (rst || rst_cnt != rc0) ab = 1'b1;
            end
            if (!ab) begin
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", 32'd1, 32'd0);
               end else begin
                  d = sb_q.pop_front();
                  chk("rx_first", {20'd0, of}, {20'd0, frame_bits(d, par_v[sel])});
                  chk("rx_last",  {20'd0, ol}, {20'd0, frame_bits(d, par_v[sel])});
                  n_rx++;
               end
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d, input bit push);
      data_v[i]  = d;
      start_v[i] = 1'b1;
      if (push) sb_q.push_back(d);
      @(posedge clk); #1;
      start_v[i] = 1'b0;
   endtask

   // Counts busy cycles from the current sample until busy drops (bounded).
   task automatic measure(input int i, output int n, output int nd);
      n  = 0;
      nd = 0;
      while (busy_v[i] && n < 20000) begin
         n++;
         if (done_v[i]) nd++;
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input int i);
      int g;
      g = 0;
      while (busy_v[i] && g < 20000) begin @(posedge clk); #1; g++; end
      chk("idle_wait", {31'd0, busy_v[i]}, 32'd0);
   endtask

   task automatic wait_sb(input string tag);
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 20000) begin @(posedge clk); #1; g++; end
      chk(tag, sb_q.size(), 32'd0);
   endtask

   initial begin
      int n, nd, n0, anyb;
      for (int i = 0; i < 5; i++) data_v[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd",  {27'd0, txd_v},  32'h1F);
      chk("rst_busy", {27'd0, busy_v}, 32'h0);
      chk("rst_done", {27'd0, done_v}, 32'h0);

      // Default 8N1, 0x41. The first request after reset release is taken on the next edge.
      sel = 0;
      rst = 1'b0;
      send(0, 8'h41, 1);
      chk("first_accept", {31'd0, busy_v[0]}, 32'd1);
      measure(0, n, nd);
      chk("len_8n1", n, 32'd4340);
      chk("done_in_busy", nd, 32'd0);
      chk("done_pulse", {31'd0, done_v[0]}, 32'd1);
      @(posedge clk); #1;
      chk("done_1cyc", {31'd0, done_v[0]}, 32'd0);
      wait_sb("sb_8n1");

      // A request mid-frame is ignored: only 0x55 goes out.
      n0 = n_rx;
      send(0, 8'h55, 1);
      repeat (99) begin @(posedge clk); #1; end
      send(0, 8'hAA, 0);
      wait_idle(0);
      anyb = 0;
      repeat (20) begin @(posedge clk); #1; if (busy_v[0]) anyb = 1; end
      chk("no_second", anyb, 32'd0);
      wait_sb("sb_ignore");
      chk("rx_ignore", n_rx - n0, 32'd1);

      // Back-to-back: the second request lands in the tx_done cycle.
      send(0, 8'h00, 1);
      measure(0, n, nd);
      chk("b2b_done", {31'd0, done_v[0]}, 32'd1);
      send(0, 8'hFF, 1);
      chk("b2b_gap", {31'd0, busy_v[0]}, 32'd1);
      measure(0, n, nd);
      chk("b2b_len2", n, 32'd4340);
      wait_sb("sb_b2b");

      // Reset during data bit 3 forces the line idle without waiting for a clock edge.
      send(0, 8'hC3, 0);
      repeat (4 * 434 + 200 - 1) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_txd",  {31'd0, txd_v[0]},  32'd1);
      chk("rst_mid_busy", {31'd0, busy_v[0]}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (1000) begin @(posedge clk); #1; end
      send(0, 8'h5A, 1);
      measure(0, n, nd);
      chk("len_after_rst", n, 32'd4340);
      wait_sb("sb_rst");

      // Even parity
      sel = 1;
      send(1, 8'h41, 1);
      measure(1, n, nd);
      chk("len_8e1", n, 32'd4774);
      wait_sb("sb_even");

      // Odd parity, two stop bits
      sel = 2;
      send(2, 8'h41, 1);
      measure(2, n, nd);
      chk("len_8o2", n, 32'd5208);
      wait_sb("sb_odd");

      // 16 random bytes, sending only while busy is low
      sel = 3;
      n0 = n_rx;
      for (int k = 0; k < 16; k++) begin
         wait_idle(3);
         send(3, 8'($urandom_range(0, 255)), 1);
      end
      wait_idle(3);
      wait_sb("sb_rand");
      chk("rx_rand", n_rx - n0, 32'd16);

      // Illegal PARITY/STOP_BITS values behave as 8N1 at 8 clocks per bit.
      sel = 4;
      send(4, 8'h96, 1);
      measure(4, n, nd);
      chk("len_illegal", n, 32'd80);
      wait_sb("sb_illegal");

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
